// File: rtl/mmio_console_fifo_pkg.sv
// Shared console definitions: bus widths, register window, register offsets and bit positions.
// Test programs and the outer bus decoder use these same values.
package mmio_console_fifo_pkg;

   localparam int unsigned ADDR_W = 26;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] CONSOLE_BASE_ADDR = 26'h3FFFFFC;

   localparam logic [1:0] OFF_TXDATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS   = 2'd1;
   localparam logic [1:0] OFF_CTRL     = 2'd2;
   localparam logic [1:0] OFF_RESERVED = 2'd3;

   localparam int unsigned STATUS_EMPTY_BIT = 0;
   localparam int unsigned STATUS_FULL_BIT  = 1;
   localparam int unsigned STATUS_OVF_BIT   = 2;
   localparam int unsigned STATUS_COUNT_LSB = 8;

   localparam int unsigned CTRL_CLR_FIFO_BIT = 0;
   localparam int unsigned CTRL_CLR_OVF_BIT  = 1;

endpackage

// File: rtl/mmio_console_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO with clear; push while full is accepted only alongside a pop.
module mmio_console_fifo_sync_fifo #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  clear,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign full  = (count == (DEPTH_LOG2 + 1)'(DEPTH));
   assign empty = (count == '0);
   assign rdata = empty ? '0 : mem[rd_ptr];

   // Clear wins over a same-cycle pop; a full FIFO takes a push only if the head leaves.
   assign do_pop  = pop & ~empty & ~clear;
   assign do_push = push & ~clear & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_console_fifo.sv
// Memory-mapped console: 4-word register window feeding a character FIFO drained over valid/ready.
module mmio_console_fifo
   import mmio_console_fifo_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR  = CONSOLE_BASE_ADDR,
   parameter int unsigned       DEPTH      = 16,
   parameter int unsigned       DEPTH_LOG2 = 4,
   parameter int unsigned       CHAR_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [ADDR_W-1:0]     ADDR,
   input  logic [DATA_W-1:0]     WDATA,
   input  logic                  READ,
   input  logic                  WRITE,
   output logic [DATA_W-1:0]     RDATA,
   output logic                  HIT,
   output logic [CHAR_WIDTH-1:0] TX_DATA,
   output logic                  TX_VALID,
   input  logic                  TX_READY
);

   logic [ADDR_W-1:0]   offset_full;
   logic [1:0]          offset;
   logic                rd_en;
   logic                wr_en;
   logic                push;
   logic                pop;
   logic                clear_fifo;
   logic                clear_ovf;
   logic                full;
   logic                empty;
   logic [DEPTH_LOG2:0] count;
   logic [7:0]          count8;
   logic                ovf;

   assign offset_full = ADDR - BASE_ADDR;
   assign offset      = offset_full[1:0];
   assign HIT         = (ADDR >= BASE_ADDR) && (offset_full < ADDR_W'(4));

   assign rd_en = HIT & READ & ~WRITE;
   assign wr_en = HIT & WRITE & ~READ;

   assign push       = wr_en && (offset == OFF_TXDATA);
   assign pop        = TX_VALID & TX_READY;
   assign clear_fifo = wr_en && (offset == OFF_CTRL) && WDATA[CTRL_CLR_FIFO_BIT];
   assign clear_ovf  = wr_en && (offset == OFF_CTRL) && WDATA[CTRL_CLR_OVF_BIT];

   assign TX_VALID = ~empty;
   assign count8   = 8'(count);

   always_comb begin
      RDATA = '0;
      if (rd_en && (offset == OFF_STATUS)) begin
         RDATA[STATUS_COUNT_LSB +: 8] = count8;
         RDATA[STATUS_OVF_BIT]        = ovf;
         RDATA[STATUS_FULL_BIT]       = full;
         RDATA[STATUS_EMPTY_BIT]      = empty;
      end
   end

   // Sticky until cleared through CTRL; a later dropped push sets it again.
   always_ff @(posedge CLK) begin
      if (RST)                            ovf <= 1'b0;
      else if (clear_ovf)                 ovf <= 1'b0;
      else if (push && full && !pop)      ovf <= 1'b1;
   end

   mmio_console_fifo_sync_fifo #(
      .WIDTH      (CHAR_WIDTH),
      .DEPTH      (DEPTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (push),
      .pop   (pop),
      .clear (clear_fifo),
      .wdata (WDATA[CHAR_WIDTH-1:0]),
      .rdata (TX_DATA),
      .full  (full),
      .empty (empty),
      .count (count)
   );

endmodule

// File: tb/tb_mmio_console_fifo.sv
// Directed bench for mmio_console_fifo with hand-computed expectations.
module tb_mmio_console_fifo;

   localparam logic [25:0] BASE = 26'h3FFFFFC;

   logic        CLK = 1'b0;
   logic        RST;
   logic [25:0] ADDR;
   logic [31:0] WDATA;
   logic        READ;
   logic        WRITE;
   logic [31:0] RDATA;
   logic        HIT;
   logic [7:0]  TX_DATA;
   logic        TX_VALID;
   logic        TX_READY;

   int n_cmp = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   mmio_console_fifo dut (
      .CLK      (CLK),
      .RST      (RST),
      .ADDR     (ADDR),
      .WDATA    (WDATA),
      .READ     (READ),
      .WRITE    (WRITE),
      .RDATA    (RDATA),
      .HIT      (HIT),
      .TX_DATA  (TX_DATA),
      .TX_VALID (TX_VALID),
      .TX_READY (TX_READY)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [1:0] off, input logic [31:0] data);
      ADDR  = BASE + 26'(off);
      WDATA = data;
      WRITE = 1'b1;
      tick();
      WRITE = 1'b0;
   endtask

   task automatic status(input string tag, input logic [31:0] exp);
      ADDR = BASE + 26'd1;
      READ = 1'b1;
      #1;
      check(tag, RDATA, exp);
      READ = 1'b0;
      #1;
   endtask

   initial begin
      RST = 1'b1; ADDR = '0; WDATA = '0; READ = 1'b0; WRITE = 1'b0; TX_READY = 1'b0;
      tick(); tick();
      RST = 1'b0;
      tick(); tick(); tick();

      // Reset state and decode
      check("rst_valid", 32'(TX_VALID), 32'd0);
      check("rst_data", 32'(TX_DATA), 32'd0);
      check("hit_addr0", 32'(HIT), 32'd0);
      ADDR = BASE - 26'd1; #1;
      check("hit_below", 32'(HIT), 32'd0);
      ADDR = BASE + 26'd3; #1;
      check("hit_top", 32'(HIT), 32'd1);
      READ = 1'b1; #1;
      check("reserved_rd", RDATA, 32'd0);
      READ = 1'b0;
      status("rst_status", 32'h00000001);

      // Two characters, sink stalled
      wr(2'd0, 32'h48);
      check("h_valid", 32'(TX_VALID), 32'd1);
      check("h_data", 32'(TX_DATA), 32'h48);
      wr(2'd0, 32'h69);
      status("hi_status", 32'h00000200);

      // Drain both
      TX_READY = 1'b1;
      check("drain0", 32'(TX_DATA), 32'h48);
      tick();
      check("drain1", 32'(TX_DATA), 32'h69);
      tick();
      TX_READY = 1'b0;
      check("drained_valid", 32'(TX_VALID), 32'd0);
      status("drained_status", 32'h00000001);

      // Fill to full, then overflow
      for (int i = 0; i < 16; i++) wr(2'd0, 32'(i));
      status("full_status", 32'h00001002);
      wr(2'd0, 32'h10);
      status("ovf_status", 32'h00001006);
      TX_READY = 1'b1;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("ovf_drain%0d", i), 32'(TX_DATA), 32'(i));
         tick();
      end
      TX_READY = 1'b0;
      check("ovf_drained_valid", 32'(TX_VALID), 32'd0);
      status("ovf_sticky", 32'h00000005);
      wr(2'd2, 32'h2);
      status("ovf_cleared", 32'h00000001);

      // Full with ovf set, then push with simultaneous pop
      for (int i = 0; i < 16; i++) wr(2'd0, 32'h20 + 32'(i));
      wr(2'd0, 32'h99);
      status("full_ovf", 32'h00001006);
      TX_READY = 1'b1;
      check("pp_head", 32'(TX_DATA), 32'h20);
      wr(2'd0, 32'h30);
      TX_READY = 1'b0;
      status("pp_status", 32'h00001006);
      TX_READY = 1'b1;
      for (int i = 0; i < 15; i++) begin
         check($sformatf("pp_drain%0d", i), 32'(TX_DATA), 32'h21 + 32'(i));
         tick();
      end
      check("pp_last", 32'(TX_DATA), 32'h30);
      // Clear both while the sink is ready; clear overrides the pop
      wr(2'd2, 32'h3);
      TX_READY = 1'b0;
      check("clr_valid", 32'(TX_VALID), 32'd0);
      status("clr_status", 32'h00000001);

      // READ and WRITE together is a no-op
      ADDR = BASE + 26'd1; READ = 1'b1; WRITE = 1'b1; WDATA = 32'h55; #1;
      check("rw_status_rdata", RDATA, 32'd0);
      ADDR = BASE; #1;
      check("rw_rdata", RDATA, 32'd0);
      tick();
      READ = 1'b0; WRITE = 1'b0;
      check("rw_no_push", 32'(TX_VALID), 32'd0);

      // Reset with data buffered
      for (int i = 0; i < 5; i++) wr(2'd0, 32'hA0 + 32'(i));
      status("five_status", 32'h00000500);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("mid_rst_valid", 32'(TX_VALID), 32'd0);
      check("mid_rst_data", 32'(TX_DATA), 32'd0);
      status("mid_rst_status", 32'h00000001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
